// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fft_pkg
// Description : Shared definitions for the FFT output denormalizer: the
//               frame-control FSM state type, the largest supported frame
//               length (as log2) and the width of the saturation counter.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Largest frame accepted is 2^FFT_LEN_LOG2_MAX samples.
  localparam int FFT_LEN_LOG2_MAX = 12;

  // Width of the per-frame saturated-sample counter.
  localparam int SAT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } denorm_state_e;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_sat_shift.sv
`default_nettype none
// ============================================================================
// Module      : fft_sat_shift
// Description : Combinational saturating arithmetic left shift for one
//               sample component. The sample is sign-extended to OUT_WIDTH
//               and shifted left by 'shift'. If the exact result does not fit
//               in OUT_WIDTH, the output clamps to the most positive or most
//               negative value according to the sample sign. A zero sample
//               gives zero for any shift and never saturates.
// Ports       : sample    - signed input component (DATA_WIDTH)
//               shift     - left shift amount (SHIFT_WIDTH, unsigned)
//               result    - signed shifted/saturated result (OUT_WIDTH)
//               saturated - high when result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module fft_sat_shift #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0]  sample,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [OUT_WIDTH-1:0]   result,
  output logic                          saturated
);

  localparam logic signed [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH-1:0] extended;
  logic signed [OUT_WIDTH-1:0] shifted;
  logic signed [OUT_WIDTH-1:0] restored;
  logic                        shift_too_big;

  assign extended      = {{(OUT_WIDTH-DATA_WIDTH){sample[DATA_WIDTH-1]}}, sample};
  assign shift_too_big = (32'(shift) >= 32'(OUT_WIDTH));
  assign shifted       = extended <<< shift;
  // Shifting back arithmetically recovers the original value only when no
  // significant bit (or sign change) was lost off the top.
  assign restored      = shifted >>> shift;

  always_comb begin
    result    = shifted;
    saturated = 1'b0;
    if (sample == '0) begin
      result = '0;
    end else if (shift_too_big || (restored != extended)) begin
      saturated = 1'b1;
      result    = sample[DATA_WIDTH-1] ? NEG_MIN : POS_MAX;
    end
  end

endmodule : fft_sat_shift
`default_nettype wire

// File: rtl/fft_output_denormalizer.sv
`default_nettype none
// ============================================================================
// Module      : fft_output_denormalizer
// Description : Undoes the accumulated block-floating-point scaling of an
//               FFT output frame. Each accepted complex sample is
//               sign-extended and shifted left by the scale factor latched at
//               frame start, saturating on overflow. A single output register
//               gives one cycle of latency with valid/ready back-pressure.
//               Frame length, last-sample marking, a done pulse and a sticky
//               error flag are handled by a three-state control FSM.
// Config      : `define FFT_DENORM_SAT_STATS_EN to enable the per-frame
//               saturated-sample counter on sat_count_o; otherwise
//               sat_count_o is tied to zero (data saturation is unaffected).
// Ports       : clk_i, reset_n_i (async, active-low)
//               frame_start_i, frame_len_log2_i, total_scale_factor_i,
//               scale_factor_overflow_i          - frame configuration
//               s_valid_i/s_ready_o/s_real_i/s_imag_i - input stream
//               m_valid_o/m_ready_i/m_real_o/m_imag_o/m_last_o - output stream
//               busy_o, frame_done_o, error_o, sat_count_o - status
// Revision    : 1.0 - initial release
// ============================================================================
module fft_output_denormalizer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int OUT_WIDTH          = 32,
  parameter int SCALE_FACTOR_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          frame_start_i,
  input  logic [3:0]                    frame_len_log2_i,
  input  logic [SCALE_FACTOR_WIDTH-1:0] total_scale_factor_i,
  input  logic                          scale_factor_overflow_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic signed [DATA_WIDTH-1:0]  s_real_i,
  input  logic signed [DATA_WIDTH-1:0]  s_imag_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic signed [OUT_WIDTH-1:0]   m_real_o,
  output logic signed [OUT_WIDTH-1:0]   m_imag_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic                          error_o,
  output logic [SAT_COUNT_WIDTH-1:0]    sat_count_o
);

  denorm_state_e                 state;
  denorm_state_e                 state_next;

  logic [SCALE_FACTOR_WIDTH-1:0] scale;
  logic [3:0]                    len_log2;
  logic [FFT_LEN_LOG2_MAX-1:0]   sample_cnt;
  logic [FFT_LEN_LOG2_MAX-1:0]   last_idx;

  logic                          len_ok;
  logic                          start_ok;
  logic                          accept;
  logic                          is_last;
  logic                          out_hs;

  logic signed [OUT_WIDTH-1:0]   real_shifted;
  logic signed [OUT_WIDTH-1:0]   imag_shifted;
  logic                          real_sat;
  logic                          imag_sat;

  assign len_ok   = (frame_len_log2_i != 4'd0) &&
                    (frame_len_log2_i <= 4'(FFT_LEN_LOG2_MAX));
  assign start_ok = (state == IDLE) && frame_start_i && len_ok;
  assign accept   = s_valid_i && s_ready_o;
  assign out_hs   = m_valid_o && m_ready_i;

  // Index of the final sample, 2^len-1. len_log2 only ever holds a validated
  // value (1..FFT_LEN_LOG2_MAX), so the subtraction cannot underflow.
  assign last_idx = {FFT_LEN_LOG2_MAX{1'b1}} >> (4'(FFT_LEN_LOG2_MAX) - len_log2);
  assign is_last  = (sample_cnt == last_idx);

  // --------------------------------------------------------------------------
  // Datapath: one saturating shifter per component.
  // --------------------------------------------------------------------------
  fft_sat_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SCALE_FACTOR_WIDTH)
  ) u_real_shift (
    .sample    (s_real_i),
    .shift     (scale),
    .result    (real_shifted),
    .saturated (real_sat)
  );

  fft_sat_shift #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT_WIDTH (SCALE_FACTOR_WIDTH)
  ) u_imag_shift (
    .sample    (s_imag_i),
    .shift     (scale),
    .result    (imag_shifted),
    .saturated (imag_sat)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) state_next = STREAM;
      end
      STREAM: begin
        if (accept && is_last) state_next = DRAIN;
      end
      DRAIN: begin
        if (out_hs && m_last_o) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    s_ready_o    = 1'b0;
    busy_o       = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      STREAM: begin
        busy_o    = 1'b1;
        // The output register can take a new sample if it is empty or is
        // being emptied this cycle.
        s_ready_o = !m_valid_o || m_ready_i;
      end
      DRAIN: begin
        busy_o       = 1'b1;
        frame_done_o = out_hs && m_last_o;
      end
      default: begin
        s_ready_o    = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame configuration captured at a valid start
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scale    <= '0;
      len_log2 <= 4'd1;
    end else if (start_ok) begin
      scale    <= total_scale_factor_i;
      len_log2 <= frame_len_log2_i;
    end
  end

  // Accepted-sample counter; wraps harmlessly after the last sample.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sample_cnt <= '0;
    end else if (start_ok) begin
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output register (single skid-free stage, latency 1)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
      m_real_o  <= '0;
      m_imag_o  <= '0;
    end else if (accept) begin
      m_valid_o <= 1'b1;
      m_last_o  <= is_last;
      m_real_o  <= real_shifted;
      m_imag_o  <= imag_shifted;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
      m_last_o  <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error: a valid start clears it (unless the tracker overflowed);
  // a bad length or a start while busy sets it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_o <= 1'b0;
    end else if (frame_start_i) begin
      if (state == IDLE) begin
        error_o <= len_ok ? scale_factor_overflow_i : 1'b1;
      end else begin
        error_o <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Saturation statistics
  // --------------------------------------------------------------------------
`ifdef FFT_DENORM_SAT_STATS_EN
  logic [SAT_COUNT_WIDTH-1:0] sat_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sat_count <= '0;
    end else if (start_ok) begin
      sat_count <= '0;
    end else if (accept && (real_sat || imag_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign sat_count_o = sat_count;
`else
  logic sat_flags_unused;

  assign sat_flags_unused = real_sat | imag_sat;
  assign sat_count_o      = '0;
`endif

endmodule : fft_output_denormalizer
`default_nettype wire
